// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a mem req/ready watchdog.
// Optional PERF_CNT_EN adds cycle and retired-instruction counters (cyc_cnt, ret_cnt).
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       PctoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] state,
    output logic       illegal,
    output logic       bus_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    state_t          state_q, state_d;
    logic [5:0]      op_q, op_d, funct_q, funct_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic            waiting;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct_d   = funct_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        cnt_d     = '0;
        waiting   = 1'b0;
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        MemtoReg  = 1'b0;
        PctoReg   = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 2'b00;
        ALUOp     = 2'b00;
        case (state_q)
            S_IDLE: if (en) state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                op_d    = opcode;
                funct_d = funct;
                case (opcode)
                    OP_J: begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b10;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b10;
                        state_d = S_WB;
                    end
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_ORI: state_d = S_EXEC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op_q)
                    OP_R: begin
                        if (funct_q == FN_JR) begin
                            PCWrite = 1'b1;
                            PCSrc   = 2'b11;
                            state_d = S_FETCH;
                        end else begin
                            ALUOp = 2'b10;
                        end
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_ORI: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 2'b11;
                    end
                    OP_BEQ: begin
                        ALUOp   = 2'b01;
                        PCWrite = zero;
                        PCSrc   = 2'b01;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q != OP_LW);
                if (mem_ready) state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                else           waiting = 1'b1;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_R);
                MemtoReg = (op_q == OP_LW);
                PctoReg  = (op_q == OP_JAL);
                state_d  = S_FETCH;
            end
            default: ;
        endcase
        // Watchdog fires in the cycle the stall count reaches the limit.
        if (waiting) begin
            cnt_d = cnt_inc;
            if (MEM_TIMEOUT != 0 && cnt_inc == TO_LIM) begin
                bus_err_d = 1'b1;
                state_d   = S_HALT;
            end
        end
    end

    assign state   = state_q;
    assign illegal = illegal_d;
    assign bus_err = bus_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            funct_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cyc_q, ret_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + 32'd1;
            if (state_d == S_FETCH && state_q != S_IDLE && state_q != S_FETCH) ret_q <= ret_q + 32'd1;
        end
    end
    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: instruction table, per-instruction timeline model with random waits, corner sequences.
module tb_mc_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst_n, en, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       RegDst, ALUSrc, MemtoReg, PctoReg, RegWrite, MemRead, MemWrite, IRWrite, PCWrite;
    logic [1:0] PCSrc, ALUOp;
    logic [2:0] state;
    logic       illegal, bus_err;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    mc_ctrl_fsm #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .PctoReg(PctoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state),
        .illegal(illegal), .bus_err(bus_err)
`ifdef PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {RegDst, ALUSrc, MemtoReg, PctoReg, RegWrite, MemRead, MemWrite, IRWrite,
                  PCWrite, PCSrc, ALUOp, state, illegal, bus_err};

    localparam logic [17:0] REGDST = 18'd1 << 17, ALUSRC = 18'd1 << 16, MEMTOREG = 18'd1 << 15;
    localparam logic [17:0] PCTOREG = 18'd1 << 14, REGWR = 18'd1 << 13, MEMRD = 18'd1 << 12;
    localparam logic [17:0] MEMWR = 18'd1 << 11, IRWR = 18'd1 << 10, PCWR = 18'd1 << 9;
    localparam logic [17:0] PC_BR = 18'd1 << 7, PC_J = 18'd2 << 7, PC_JR = 18'd3 << 7;
    localparam logic [17:0] ALU_SUB = 18'd1 << 5, ALU_FN = 18'd2 << 5, ALU_OR = 18'd3 << 5;
    localparam logic [17:0] ILL = 18'd2, BERR = 18'd1;
    localparam logic [5:0] R = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, ORI = 6'h0D, LW = 6'h23, SW = 6'h2B;

    function automatic logic [17:0] st(input int s);
        return 18'(s) << 2;
    endfunction

    int vec = 0, mism = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected per-cycle timeline: inputs to drive and outputs to see.
    typedef struct {
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [17:0] exp;
    } cyc_t;
    cyc_t tl[$];
    int   tl_idx = 0;

    task automatic push(input logic mr, input logic z, input logic [5:0] op, input logic [5:0] fn,
                        input logic [17:0] exp);
        cyc_t c;
        c.mr = mr; c.z = z; c.op = op; c.fn = fn; c.exp = exp;
        tl.push_back(c);
    endtask

    task automatic push_rnd(input logic mr, input logic [17:0] exp);
        push(mr, 1'($urandom), 6'($urandom), 6'($urandom), exp);
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                             input logic zb);
        logic [17:0] macc;
        for (int i = 0; i < fw; i++) push_rnd(1'b0, st(1) | MEMRD);
        push_rnd(1'b1, st(1) | MEMRD | IRWR | PCWR);
        if (op == J) begin
            push(1'($urandom), 1'($urandom), op, fn, st(2) | PCWR | PC_J);
            return;
        end
        if (op == JAL) begin
            push(1'($urandom), 1'($urandom), op, fn, st(2) | PCWR | PC_J);
            push_rnd(1'($urandom), st(5) | REGWR | PCTOREG);
            return;
        end
        if (!(op inside {R, LW, SW, BEQ, ORI})) begin
            push(1'($urandom), 1'($urandom), op, fn, st(2) | ILL);
            for (int i = 0; i < 3; i++) push_rnd(1'($urandom), st(6) | ILL);
            return;
        end
        push(1'($urandom), 1'($urandom), op, fn, st(2));
        if (op == R && fn == 6'h08) begin
            push_rnd(1'($urandom), st(3) | PCWR | PC_JR);
        end else if (op == R) begin
            push_rnd(1'($urandom), st(3) | ALU_FN);
            push_rnd(1'($urandom), st(5) | REGWR | REGDST);
        end else if (op == ORI) begin
            push_rnd(1'($urandom), st(3) | ALUSRC | ALU_OR);
            push_rnd(1'($urandom), st(5) | REGWR);
        end else if (op == BEQ) begin
            push(1'($urandom), zb, 6'($urandom), 6'($urandom), st(3) | ALU_SUB | PC_BR | (zb ? PCWR : 18'd0));
        end else begin
            push_rnd(1'($urandom), st(3) | ALUSRC);
            macc = st(4) | ((op == LW) ? MEMRD : MEMWR);
            for (int i = 0; i < mw; i++) push_rnd(1'b0, macc);
            push_rnd(1'b1, macc);
            if (op == LW) push_rnd(1'($urandom), st(5) | REGWR | MEMTOREG);
        end
    endtask

    task automatic run_tl();
        cyc_t c;
        while (tl.size() > 0) begin
            c = tl.pop_front();
            mem_ready = c.mr; zero = c.z; opcode = c.op; funct = c.fn; en = 1'($urandom);
            @(negedge clk);
            chk($sformatf("cyc%0d", tl_idx), 32'(obs), 32'(c.exp));
            tl_idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1 chk("reset_outs", 32'(obs), 32'd0);
`ifdef PERF_CNT_EN
        chk("reset_cyc", cyc_cnt, 32'd0);
        chk("reset_ret", ret_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic start();
        en = 1'b0; mem_ready = 1'b1;
        @(negedge clk); chk("idle_outs", 32'(obs), 32'd0);
        @(posedge clk); #1; chk("idle_hold", 32'(state), 32'd0);
        en = 1'b1;
        @(negedge clk); chk("idle_en", 32'(obs), 32'd0);
        @(posedge clk); #1; chk("to_fetch", 32'(state), 32'd1);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         len;
        int         n_rw;
        int         n_pcw;
    } vec_t;
    vec_t tbl[9];

    logic [5:0] ops[8];

    initial begin
        int n, rw, pcw, k, fw, mw;
        logic [5:0] fn;
        tbl[0] = '{R,    6'h21, 1'b0, 4, 1, 1};
        tbl[1] = '{R,    6'h08, 1'b0, 3, 0, 2};
        tbl[2] = '{LW,   6'h00, 1'b0, 5, 1, 1};
        tbl[3] = '{SW,   6'h00, 1'b0, 4, 0, 1};
        tbl[4] = '{BEQ,  6'h00, 1'b1, 3, 0, 2};
        tbl[5] = '{BEQ,  6'h00, 1'b0, 3, 0, 1};
        tbl[6] = '{ORI,  6'h00, 1'b0, 4, 1, 1};
        tbl[7] = '{J,    6'h00, 1'b0, 2, 0, 2};
        tbl[8] = '{JAL,  6'h00, 1'b0, 3, 1, 2};
        ops = '{R, R, LW, SW, BEQ, ORI, J, JAL};

        rst_n = 1'b0; en = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
        #1 do_reset();
        start();

        foreach (tbl[i]) begin
            n = 0; rw = 0; pcw = 0;
            do begin
                opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z; mem_ready = 1'b1;
                en = 1'($urandom);
                @(negedge clk);
                rw += int'(RegWrite);
                pcw += int'(PCWrite);
                @(posedge clk); #1;
                n++;
            end while (state != 3'd1 && n < 20);
            chk($sformatf("tbl%0d_len", i), 32'(n), 32'(tbl[i].len));
            chk($sformatf("tbl%0d_regwr", i), 32'(rw), 32'(tbl[i].n_rw));
            chk($sformatf("tbl%0d_pcwr", i), 32'(pcw), 32'(tbl[i].n_pcw));
        end
`ifdef PERF_CNT_EN
        chk("ret_after_tbl", ret_cnt, 32'd9);
`endif

        // lw with a 3-cycle memory stall: MemRead held four cycles in MEM.
        gen_instr(LW, 6'h00, 0, 3, 1'b0);
        run_tl();

        // Random program; stalls up to 15 cycles exercise the watchdog boundary and clearing.
        for (int t = 0; t < 60; t++) begin
            k = int'($urandom % 8);
            fn = (k == 1) ? 6'h08 : 6'($urandom);
            if (k == 0 && fn == 6'h08) fn = 6'h20;
            fw = ($urandom % 8 == 0) ? 15 : int'($urandom % 4);
            mw = ($urandom % 8 == 0) ? 15 : int'($urandom % 4);
            gen_instr(ops[k], fn, fw, mw, 1'($urandom));
            run_tl();
        end

        // Reset asserted while a lw is stalled in MEM.
        push_rnd(1'b1, st(1) | MEMRD | IRWR | PCWR);
        push(1'b0, 1'b0, LW, 6'h00, st(2));
        push_rnd(1'b0, st(3) | ALUSRC);
        run_tl();
        mem_ready = 1'b0; en = 1'b0;
        @(negedge clk); chk("mem_stall", 32'(obs), 32'(st(4) | MEMRD));
        #2 rst_n = 1'b0;
        #1 chk("rst_in_mem", 32'(obs), 32'd0);
`ifdef PERF_CNT_EN
        chk("rst_cyc", cyc_cnt, 32'd0);
        chk("rst_ret", ret_cnt, 32'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        start();

        // Unsupported opcode halts with sticky illegal.
        gen_instr(6'h3F, 6'h00, 1, 0, 1'b0);
        run_tl();
        do_reset();
        start();

        // Memory never responds in FETCH: watchdog.
        n = 0;
        k = 0;
        while (k == 0 && n < 40) begin
            mem_ready = 1'b0;
            @(negedge clk);
            if (state == 3'd6) k = 1;
            else n++;
            @(posedge clk); #1;
        end
        chk("to_fetch_cycles", 32'(n), 32'd16);
        chk("to_halt", 32'(obs), 32'(st(6) | BERR));
        mem_ready = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        chk("to_sticky", 32'(obs), 32'(st(6) | BERR));

        $display("== %0d vectors applied, %0d miscompares ==", vec, mism);
        $finish;
    end
endmodule
